// File: rtl/fifo_share_ctrl.sv
// rtl/fifo_share_ctrl.sv - shared display-FIFO write arbiter and read-to-stream sequencer
// Optional build macro: FIFO_SHARE_FIXED_PRI_EN (fixed priority, requester 0 highest).
module fifo_share_ctrl #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_fifo_wr,
  output logic [DATA_W-1:0]       o_fifo_din,
  input  logic                    i_fifo_full,
  output logic                    o_fifo_rd,
  input  logic [DATA_W-1:0]       i_fifo_dout,
  input  logic                    i_fifo_empty,
  output logic                    o_valid,
  output logic [DATA_W-1:0]       o_data,
  input  logic                    i_ready
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {W_IDLE, W_HOLD} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_LATCH, R_PRESENT} r_state_t;

  w_state_t         w_state;
  r_state_t         r_state;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;

`ifdef FIFO_SHARE_FIXED_PRI_EN
  // Descending scan so the lowest-indexed active requester is the last writer.
  always_comb begin
    grant_any = |i_req;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) grant_idx = PTR_W'(i);
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] cand;

  // Scan offsets from the far end back to rr_ptr so the nearest request wins.
  always_comb begin
    grant_any = |i_req;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = rr_ptr + PTR_W'(i);
      if (i_req[cand]) grant_idx = cand;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state    <= W_IDLE;
      o_ack      <= '0;
      o_fifo_wr  <= 1'b0;
      o_fifo_din <= '0;
`ifndef FIFO_SHARE_FIXED_PRI_EN
      rr_ptr     <= '0;
`endif
    end else begin
      case (w_state)
        W_IDLE: begin
          if (grant_any && !i_fifo_full) begin
            o_fifo_wr  <= 1'b1;
            o_fifo_din <= i_req_data[grant_idx*DATA_W +: DATA_W];
            o_ack      <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
`ifndef FIFO_SHARE_FIXED_PRI_EN
            rr_ptr     <= grant_idx + PTR_W'(1);
`endif
            w_state    <= W_HOLD;
          end
        end
        // One dead cycle lets the FIFO full flag reflect the write just issued.
        W_HOLD: begin
          o_fifo_wr <= 1'b0;
          o_ack     <= '0;
          w_state   <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= R_IDLE;
      o_fifo_rd <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (!i_fifo_empty && !o_valid) begin
            o_fifo_rd <= 1'b1;
            r_state   <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          o_fifo_rd <= 1'b0;
          r_state   <= R_LATCH;
        end
        R_LATCH: begin
          o_data  <= i_fifo_dout;
          o_valid <= 1'b1;
          r_state <= R_PRESENT;
        end
        R_PRESENT: begin
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
